alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer slice.
// Holds the sequencer state encoding, the opcode width and the default datapath width.
package alu_pkg;

   localparam int OP_W  = 3;
   localparam int W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

endpackage

// File: rtl/alu_regfile.sv
// General register file: NREG x W, two asynchronous read ports, one synchronous write port.
// All entries clear asynchronously on reset.
module alu_regfile #(
   parameter int W    = 8,
   parameter int NREG = 4,
   localparam int RW  = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [RW-1:0] wa,
   input  logic [W-1:0]  wd,
   input  logic [RW-1:0] ra1,
   output logic [W-1:0]  rd1,
   input  logic [RW-1:0] ra2,
   output logic [W-1:0]  rd2
);

   logic [W-1:0] mem [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[wa] <= wd;
      end
   end

   // Read-after-write is resolved by the edge: a value written at one edge is
   // visible on the read ports for the whole following cycle.
   assign rd1 = mem[ra1];
   assign rd2 = mem[ra2];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences load-immediate and ALU instructions around an external combinational ALU.
// ALU ops take IDLE -> EXEC -> WB; loads complete in IDLE at the accepting edge.
//
// state | meaning
// IDLE  | ready for an instruction; loads write the register file directly
// EXEC  | operands presented to the external ALU; result captured at closing edge
// WB    | res_valid pulse; result written back and op_count bumped at closing edge
import alu_pkg::*;

module alu_sequencer #(
   parameter int W    = W_DEF,
   parameter int NREG = 4,
   localparam int RW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic            instr_ld,
   input  logic [OP_W-1:0] instr_op,
   input  logic [RW-1:0]   instr_rd,
   input  logic [RW-1:0]   instr_rs1,
   input  logic [RW-1:0]   instr_rs2,
   input  logic [W-1:0]    instr_imm,
   output logic [W-1:0]    alu_a,
   output logic [W-1:0]    alu_b,
   output logic [OP_W-1:0] alu_op,
   input  logic [W-1:0]    alu_out,
   output logic            res_valid,
   output logic [W-1:0]    res_data,
   output logic [RW-1:0]   res_rd,
   output logic [7:0]      op_count
);

   state_t        state_q;
   state_t        state_d;
   logic          accept;
   logic          accept_alu;
   logic          accept_ld;
   logic [RW-1:0] rd_q;
   logic [W-1:0]  result_q;

   logic          rf_we;
   logic [RW-1:0] rf_wa;
   logic [W-1:0]  rf_wd;
   logic [W-1:0]  rf_rd1;
   logic [W-1:0]  rf_rd2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid && !instr_ld) begin
               state_d = EXEC;
            end
         end
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign accept     = instr_valid & instr_ready;
   assign accept_alu = accept & ~instr_ld;
   assign accept_ld  = accept &  instr_ld;

   // Loads and write-backs never collide: loads are only accepted in IDLE.
   assign rf_we = accept_ld | (state_q == WB);
   assign rf_wa = (state_q == WB) ? rd_q     : instr_rd;
   assign rf_wd = (state_q == WB) ? result_q : instr_imm;

   alu_regfile #(
      .W    (W),
      .NREG (NREG)
   ) u_regfile (
      .clk (clk),
      .rst (rst),
      .we  (rf_we),
      .wa  (rf_wa),
      .wd  (rf_wd),
      .ra1 (instr_rs1),
      .rd1 (rf_rd1),
      .ra2 (instr_rs2),
      .rd2 (rf_rd2)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
         rd_q     <= '0;
         result_q <= '0;
         op_count <= '0;
      end else begin
         if (accept_alu) begin
            alu_a  <= rf_rd1;
            alu_b  <= rf_rd2;
            alu_op <= instr_op;
            rd_q   <= instr_rd;
         end
         if (state_q == EXEC) begin
            result_q <= alu_out;
         end
         if (state_q == WB) begin
            op_count <= op_count + 8'd1;
         end
      end
   end

   // Result outputs are gated so they read zero outside the write-back pulse.
   assign res_valid = (state_q == WB);
   assign res_data  = res_valid ? result_q : '0;
   assign res_rd    = res_valid ? rd_q     : '0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised self-checking bench for alu_sequencer with an external adder-style ALU
// and a register/op-count reference model kept at instruction level.
module tb_alu_sequencer;

   logic       clk;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic       instr_ld;
   logic [2:0] instr_op;
   logic [1:0] instr_rd;
   logic [1:0] instr_rs1;
   logic [1:0] instr_rs2;
   logic [7:0] instr_imm;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_op;
   logic [7:0] alu_out;
   logic       res_valid;
   logic [7:0] res_data;
   logic [1:0] res_rd;
   logic [7:0] op_count;

   int n_cmp;
   int n_err;

   logic [7:0] m_r [4];
   logic [7:0] m_cnt;

   alu_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_ld    (instr_ld),
      .instr_op    (instr_op),
      .instr_rd    (instr_rd),
      .instr_rs1   (instr_rs1),
      .instr_rs2   (instr_rs2),
      .instr_imm   (instr_imm),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_out     (alu_out),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_rd      (res_rd),
      .op_count    (op_count)
   );

   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a;
         3'd6:    return b;
         default: return ~a;
      endcase
   endfunction

   assign alu_out = alu_f(alu_op, alu_a, alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
      m_cnt = 8'h00;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      instr_valid = 1'b0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_load(input logic [1:0] rd, input logic [7:0] imm);
      instr_valid = 1'b1;
      instr_ld    = 1'b1;
      instr_rd    = rd;
      instr_imm   = imm;
      instr_op    = 3'($urandom);
      instr_rs1   = 2'($urandom);
      instr_rs2   = 2'($urandom);
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      m_r[rd] = imm;
      n_cmp++;
      if (instr_ready !== 1'b1 || res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL load_stays_idle ready=%0b res_valid=%0b required 1/0", instr_ready, res_valid);
      end
      n_cmp++;
      if (op_count !== m_cnt) begin
         n_err++;
         $display("FAIL load_op_count got %0h required %0h", op_count, m_cnt);
      end
   endtask

   // Starts and ends at a negedge in IDLE; junk is offered with valid high while busy.
   task automatic do_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, output logic [7:0] got);
      logic [7:0] exp;
      exp = alu_f(op, m_r[rs1], m_r[rs2]);
      n_cmp++;
      if (instr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL op_ready_idle got %0b required 1", instr_ready);
      end
      instr_valid = 1'b1;
      instr_ld    = 1'b0;
      instr_op    = op;
      instr_rd    = rd;
      instr_rs1   = rs1;
      instr_rs2   = rs2;
      instr_imm   = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      instr_ld  = 1'b1;
      instr_op  = 3'($urandom);
      instr_rd  = 2'($urandom);
      instr_rs1 = 2'($urandom);
      instr_rs2 = 2'($urandom);
      instr_imm = 8'($urandom);
      n_cmp++;
      if (alu_a !== m_r[rs1] || alu_b !== m_r[rs2] || alu_op !== op) begin
         n_err++;
         $display("FAIL exec_operands a=%0h b=%0h op=%0d required a=%0h b=%0h op=%0d",
                  alu_a, alu_b, alu_op, m_r[rs1], m_r[rs2], op);
      end
      n_cmp++;
      if (instr_ready !== 1'b0 || res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL exec_flags ready=%0b res_valid=%0b required 0/0", instr_ready, res_valid);
      end
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      got = res_data;
      n_cmp++;
      if (res_valid !== 1'b1 || instr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL wb_flags res_valid=%0b ready=%0b required 1/0", res_valid, instr_ready);
      end
      n_cmp++;
      if (res_data !== exp || res_rd !== rd) begin
         n_err++;
         $display("FAIL wb_result data=%0h rd=%0d required data=%0h rd=%0d", res_data, res_rd, exp, rd);
      end
      m_r[rd] = exp;
      m_cnt = m_cnt + 8'd1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b0 || op_count !== m_cnt) begin
         n_err++;
         $display("FAIL after_wb res_valid=%0b op_count=%0h required 0/%0h", res_valid, op_count, m_cnt);
      end
      n_cmp++;
      if (alu_a !== m_r[rs1] && rs1 != rd) begin
         n_err++;
         $display("FAIL operand_hold alu_a=%0h required %0h", alu_a, m_r[rs1]);
      end
   endtask

   task automatic test_reset();
      logic [7:0] got;
      rst = 1'b1;
      instr_valid = 1'b0;
      instr_ld = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0;
      model_clear();
      @(negedge clk);
      n_cmp++;
      if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'b000 || res_valid !== 1'b0 ||
          res_data !== 8'h00 || res_rd !== 2'd0 || op_count !== 8'h00 || instr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state a=%0h b=%0h op=%0d rv=%0b rd=%0h rr=%0d cnt=%0h rdy=%0b required zeros, ready 1",
                  alu_a, alu_b, alu_op, res_valid, res_data, res_rd, op_count, instr_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      do_load(2'd0, 8'hA5);
      do_op(3'd5, 2'd1, 2'd0, 2'd3, got);
   endtask

   task automatic test_load_add();
      logic [7:0] got;
      apply_reset();
      do_load(2'd0, 8'h19);
      do_load(2'd1, 8'h1E);
      do_op(3'd0, 2'd2, 2'd0, 2'd1, got);
      n_cmp++;
      if (got !== 8'h37) begin
         n_err++;
         $display("FAIL add_result got %0h required 37", got);
      end
      do_op(3'd5, 2'd3, 2'd2, 2'd2, got);
      n_cmp++;
      if (got !== 8'h37) begin
         n_err++;
         $display("FAIL r2_readback got %0h required 37", got);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got;
      for (int i = 0; i < 4; i++) do_load(2'(i), 8'($urandom));
      for (int k = 0; k < 8; k++) begin
         do_op(3'($urandom), 2'd2, 2'($urandom), 2'($urandom), got);
         do_op(3'($urandom), 2'($urandom), 2'd2, 2'($urandom), got);
      end
   endtask

   task automatic test_stream();
      logic [2:0] s_op  [4];
      logic [1:0] s_rd  [4];
      logic [1:0] s_rs1 [4];
      logic [1:0] s_rs2 [4];
      logic [7:0] expq [$];
      logic [1:0] rdq [$];
      int idx, pulses, last;
      logic acc;
      apply_reset();
      for (int i = 0; i < 4; i++) do_load(2'(i), 8'($urandom));
      for (int i = 0; i < 4; i++) begin
         s_op[i] = 3'($urandom); s_rd[i] = 2'($urandom);
         s_rs1[i] = 2'($urandom); s_rs2[i] = 2'($urandom);
      end
      idx = 0; pulses = 0; last = -10;
      instr_valid = 1'b1; instr_ld = 1'b0;
      instr_op = s_op[0]; instr_rd = s_rd[0]; instr_rs1 = s_rs1[0]; instr_rs2 = s_rs2[0];
      for (int cyc = 0; cyc < 16; cyc++) begin
         acc = instr_valid && instr_ready;
         @(posedge clk);
         @(negedge clk);
         if (res_valid === 1'b1) begin
            n_cmp++;
            if (expq.size() == 0 || res_data !== expq[0] || res_rd !== rdq[0] || instr_ready !== 1'b0) begin
               n_err++;
               $display("FAIL stream_pulse data=%0h rd=%0d ready=%0b pending=%0d",
                        res_data, res_rd, instr_ready, expq.size());
            end
            if (expq.size() != 0) begin
               m_r[rdq[0]] = expq[0];
               void'(expq.pop_front());
               void'(rdq.pop_front());
            end
            if (pulses > 0) begin
               n_cmp++;
               if (cyc - last != 3) begin
                  n_err++;
                  $display("FAIL stream_spacing got %0d required 3", cyc - last);
               end
            end
            last = cyc;
            pulses++;
         end
         if (acc) begin
            expq.push_back(alu_f(s_op[idx], m_r[s_rs1[idx]], m_r[s_rs2[idx]]));
            rdq.push_back(s_rd[idx]);
            n_cmp++;
            if (instr_ready !== 1'b0 || alu_a !== m_r[s_rs1[idx]] || alu_b !== m_r[s_rs2[idx]]) begin
               n_err++;
               $display("FAIL stream_exec ready=%0b a=%0h b=%0h required 0/%0h/%0h",
                        instr_ready, alu_a, alu_b, m_r[s_rs1[idx]], m_r[s_rs2[idx]]);
            end
            idx++;
            if (idx < 4) begin
               instr_op = s_op[idx]; instr_rd = s_rd[idx];
               instr_rs1 = s_rs1[idx]; instr_rs2 = s_rs2[idx];
            end else begin
               instr_valid = 1'b0;
            end
         end
      end
      instr_valid = 1'b0;
      n_cmp++;
      if (pulses != 4 || op_count !== 8'd4) begin
         n_err++;
         $display("FAIL stream_count pulses=%0d op_count=%0d required 4/4", pulses, op_count);
      end
      m_cnt = 8'd4;
   endtask

   task automatic test_reset_exec();
      logic [7:0] got;
      apply_reset();
      for (int i = 0; i < 4; i++) do_load(2'(i), 8'($urandom_range(1, 255)));
      do_op(3'd0, 2'd0, 2'd1, 2'd2, got);
      instr_valid = 1'b1; instr_ld = 1'b0;
      instr_op = 3'd3; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'b000 || res_valid !== 1'b0 ||
          res_data !== 8'h00 || op_count !== 8'h00 || instr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_exec a=%0h b=%0h op=%0d rv=%0b rd=%0h cnt=%0h rdy=%0b required zeros, ready 1",
                  alu_a, alu_b, alu_op, res_valid, res_data, op_count, instr_ready);
      end
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b0 || op_count !== 8'h00) begin
         n_err++;
         $display("FAIL reset_abort res_valid=%0b op_count=%0h required 0/0", res_valid, op_count);
      end
      for (int i = 0; i < 4; i++) do_op(3'd4, 2'(i), 2'(i), 2'((i + 1) % 4), got);
   endtask

   task automatic test_wrap();
      logic [7:0] got;
      apply_reset();
      for (int i = 0; i < 4; i++) do_load(2'(i), 8'($urandom));
      for (int k = 0; k < 256; k++) begin
         do_op(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), got);
      end
      n_cmp++;
      if (op_count !== 8'h00) begin
         n_err++;
         $display("FAIL op_count_wrap got %0h required 00", op_count);
      end
      do_load(2'd3, 8'($urandom));
      do_op(3'b111, 2'd1, 2'd3, 2'd3, got);
      n_cmp++;
      if (got !== ~m_r[3] && 2'd1 != 2'd3) begin
         n_err++;
         $display("FAIL op7_result got %0h required %0h", got, ~m_r[3]);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_load_add();
      test_back_to_back();
      test_stream();
      test_reset_exec();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
